// File: rtl/board_mode_controller_if.sv
// Front-panel signal bundle between the board I/O / supervisor side and board_mode_controller.
// The controller attaches to the slave modport; the board/supervisor side attaches to master.
interface board_mode_controller_if;
  logic [3:0] sw_i;
  logic       btn_sel_i;
  logic       busy_i;
  logic [3:0] mode_o;
  logic       mode_change_o;
  logic       pending_o;
  logic [2:0] sel_idx_o;
  logic [3:0] npu_ram_w_line_o;
  logic [2:0] led0_rgb_o;
  logic [2:0] led1_rgb_o;
  logic [2:0] led2_rgb_o;
  logic [2:0] led3_rgb_o;

  modport master (
    output sw_i, btn_sel_i, busy_i,
    input  mode_o, mode_change_o, pending_o, sel_idx_o, npu_ram_w_line_o,
    input  led0_rgb_o, led1_rgb_o, led2_rgb_o, led3_rgb_o
  );

  modport slave (
    input  sw_i, btn_sel_i, busy_i,
    output mode_o, mode_change_o, pending_o, sel_idx_o, npu_ram_w_line_o,
    output led0_rgb_o, led1_rgb_o, led2_rgb_o, led3_rgb_o
  );
endinterface

// File: rtl/board_mode_controller.sv
// Debounces the panel switches/button, commits a one-hot mode once the supervisor is idle,
// steps the NPU RAM write-line selection and drives the RGB status LEDs.
module board_mode_controller #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         CNT_W           = 20,
  parameter logic [3:0] LINE_IMG        = 4'd1,
  parameter logic [3:0] LINE_FLT_C1     = 4'd2,
  parameter logic [3:0] LINE_FLT_C3     = 4'd3,
  parameter logic [3:0] LINE_WGT_C5     = 4'd4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  board_mode_controller_if.slave  bus
);

  localparam int               NSIG    = 5;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_STABLE, S_WAIT} state_t;

  logic [NSIG-1:0] raw;
  logic [NSIG-1:0] sync1_reg;
  logic [NSIG-1:0] sync2_reg;
  logic [NSIG-1:0] db_level;

  assign raw = {bus.btn_sel_i, bus.sw_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // One counter per input: the level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  genvar gi;
  generate
    for (gi = 0; gi < NSIG; gi++) begin : g_db
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (sync2_reg[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_LAST) begin
          cnt_reg   <= '0;
          level_reg <= sync2_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign db_level[gi] = level_reg;
    end
  endgenerate

  logic [3:0] sw_db;
  logic       btn_db;
  logic [3:0] req;

  assign sw_db  = db_level[3:0];
  assign btn_db = db_level[4];

  always_comb begin
    req = 4'b0000;
    if (sw_db[3])      req = 4'b1000;
    else if (sw_db[2]) req = 4'b0100;
    else if (sw_db[1]) req = 4'b0010;
    else if (sw_db[0]) req = 4'b0001;
  end

  state_t     state_reg, state_next;
  logic [3:0] mode_reg, mode_next;
  logic       change_reg, change_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= S_STABLE;
      mode_reg   <= 4'b0000;
      change_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      change_reg <= change_next;
    end
  end

  // The target is never latched: S_WAIT compares against the live req, so the last request wins.
  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    change_next = 1'b0;
    case (state_reg)
      S_STABLE: begin
        if (req != mode_reg) begin
          if (!bus.busy_i) begin
            mode_next   = req;
            change_next = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (req == mode_reg) begin
          state_next = S_STABLE;
        end else if (!bus.busy_i) begin
          mode_next   = req;
          change_next = 1'b1;
          state_next  = S_STABLE;
        end
      end
      default: state_next = S_STABLE;
    endcase
  end

  logic       pending;
  logic       btn_prev_reg;
  logic [2:0] sel_reg, sel_next;

  assign pending = (state_reg == S_WAIT);

  // Uses mode_reg (not mode_next), so an edge coinciding with a mode commit sees the old mode.
  always_comb begin
    sel_next = sel_reg;
    if (btn_db && !btn_prev_reg && mode_reg[0] && !bus.busy_i)
      sel_next = (sel_reg == 3'd4) ? 3'd0 : sel_reg + 3'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_prev_reg <= 1'b0;
      sel_reg      <= 3'd0;
    end else begin
      btn_prev_reg <= btn_db;
      sel_reg      <= sel_next;
    end
  end

  logic [CNT_W-1:0] blink_cnt_reg;
  logic             blink;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) blink_cnt_reg <= '0;
    else       blink_cnt_reg <= blink_cnt_reg + 1'b1;
  end

  assign blink = blink_cnt_reg[CNT_W-1];

  logic [3:0]      line_reg, line_next;
  logic [3:0][2:0] led_full;
  logic [3:0][2:0] led_reg, led_next;

  always_comb begin
    line_next = 4'd0;
    if (mode_reg[0]) begin
      case (sel_reg)
        3'd1:    line_next = LINE_IMG;
        3'd2:    line_next = LINE_FLT_C1;
        3'd3:    line_next = LINE_FLT_C3;
        3'd4:    line_next = LINE_WGT_C5;
        default: line_next = 4'd0;
      endcase
    end
  end

  // led_full is what each LED shows when its mode is active; the requested one blinks that colour.
  always_comb begin
    led_full = '0;
    case (sel_reg)
      3'd1:    led_full[0] = 3'b010;
      3'd2:    led_full[0] = 3'b001;
      3'd3:    led_full[0] = 3'b011;
      3'd4:    led_full[0] = 3'b100;
      default: led_full[0] = 3'b111;
    endcase
    led_full[1] = 3'b111;
    led_full[2] = 3'b111;
    led_full[3] = 3'b111;
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_led
      always_comb begin
        led_next[gi] = 3'b000;
        if (pending && req[gi])
          led_next[gi] = blink ? led_full[gi] : 3'b000;
        else if (mode_reg[gi])
          led_next[gi] = led_full[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_reg <= 4'd0;
      led_reg  <= '0;
    end else begin
      line_reg <= line_next;
      led_reg  <= led_next;
    end
  end

  assign bus.mode_o           = mode_reg;
  assign bus.mode_change_o    = change_reg;
  assign bus.pending_o        = pending;
  assign bus.sel_idx_o        = sel_reg;
  assign bus.npu_ram_w_line_o = line_reg;
  assign bus.led0_rgb_o       = led_reg[0];
  assign bus.led1_rgb_o       = led_reg[1];
  assign bus.led2_rgb_o       = led_reg[2];
  assign bus.led3_rgb_o       = led_reg[3];

endmodule

// File: tb/tb_board_mode_controller.sv
// Scoreboarded directed test of board_mode_controller with a short debounce window.
module tb_board_mode_controller;

  logic clk;
  logic rst;

  board_mode_controller_if bus_if ();

  board_mode_controller #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mode;
    logic [11:0] leds;
    logic [3:0]  line;
  } mode_exp_t;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] line;
    logic [2:0] led0;
  } sel_exp_t;

  mode_exp_t mode_q[$];
  sel_exp_t  sel_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] leds_now();
    return {bus_if.led3_rgb_o, bus_if.led2_rgb_o, bus_if.led1_rgb_o, bus_if.led0_rgb_o};
  endfunction

  task automatic press();
    bus_if.btn_sel_i = 1'b1;
    cycles(8);
    bus_if.btn_sel_i = 1'b0;
    cycles(8);
  endtask

  task automatic expect_sel(input logic [2:0] s, input logic [3:0] l, input logic [2:0] c);
    sel_exp_t e;
    e.sel = s; e.line = l; e.led0 = c;
    sel_q.push_back(e);
  endtask

  task automatic expect_mode(input logic [3:0] m, input logic [11:0] lv, input logic [3:0] l);
    mode_exp_t e;
    e.mode = m; e.leds = lv; e.line = l;
    mode_q.push_back(e);
  endtask

  // Mode monitor: every mode_change_o pulse must match the oldest expected commit.
  initial begin
    mode_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus_if.mode_change_o) begin
        if (mode_q.size() == 0) begin
          check("unexpected_mode_change", {28'd0, bus_if.mode_o}, 32'hFFFF_FFFF);
        end else begin
          e = mode_q.pop_front();
          check("mode_commit", {28'd0, bus_if.mode_o}, {28'd0, e.mode});
          @(negedge clk);
          check("mode_leds", {20'd0, leds_now()}, {20'd0, e.leds});
          check("mode_line", {28'd0, bus_if.npu_ram_w_line_o}, {28'd0, e.line});
        end
      end
    end
  end

  // Selection monitor: every change of sel_idx_o must match the oldest expected step.
  initial begin
    sel_exp_t   e;
    logic [2:0] prev_sel = 3'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_sel = 3'd0;
      end else if (bus_if.sel_idx_o != prev_sel) begin
        prev_sel = bus_if.sel_idx_o;
        if (sel_q.size() == 0) begin
          check("unexpected_sel_step", {29'd0, bus_if.sel_idx_o}, 32'hFFFF_FFFF);
        end else begin
          e = sel_q.pop_front();
          check("sel_idx", {29'd0, bus_if.sel_idx_o}, {29'd0, e.sel});
          @(negedge clk);
          check("sel_line", {28'd0, bus_if.npu_ram_w_line_o}, {28'd0, e.line});
          check("sel_led0", {29'd0, bus_if.led0_rgb_o}, {29'd0, e.led0});
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mode"},    {28'd0, bus_if.mode_o}, 32'd0);
    check({tag, "_change"},  {31'd0, bus_if.mode_change_o}, 32'd0);
    check({tag, "_pending"}, {31'd0, bus_if.pending_o}, 32'd0);
    check({tag, "_sel"},     {29'd0, bus_if.sel_idx_o}, 32'd0);
    check({tag, "_line"},    {28'd0, bus_if.npu_ram_w_line_o}, 32'd0);
    check({tag, "_leds"},    {20'd0, leds_now()}, 32'd0);
  endtask

  initial begin
    logic [2:0]  exp_sel  [6];
    logic [3:0]  exp_line [6];
    logic [2:0]  exp_led0 [6];
    logic        saw_on, saw_off, led2_steady;
    int          pulses;

    exp_sel  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    exp_line = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
    exp_led0 = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b111, 3'b010};

    rst = 1'b1;
    bus_if.sw_i      = 4'b0000;
    bus_if.btn_sel_i = 1'b0;
    bus_if.busy_i    = 1'b0;
    cycles(3);
    check_all_zero("reset");
    rst = 1'b0;
    cycles(2);

    // Two switches rising together resolve to the higher-priority one.
    expect_mode(4'b0100, {3'b000, 3'b111, 3'b000, 3'b000}, 4'd0);
    bus_if.sw_i = 4'b0110;
    cycles(12);
    check("mode_0110", {28'd0, bus_if.mode_o}, 32'h4);

    bus_if.sw_i = 4'b1110;
    cycles(3);
    bus_if.sw_i = 4'b0110;
    cycles(10);
    check("glitch_mode", {28'd0, bus_if.mode_o}, 32'h4);

    bus_if.busy_i = 1'b1;
    bus_if.sw_i   = 4'b1000;
    cycles(20);
    check("pending_busy", {31'd0, bus_if.pending_o}, 32'd1);
    check("mode_held_busy", {28'd0, bus_if.mode_o}, 32'h4);
    saw_on = 1'b0; saw_off = 1'b0; led2_steady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus_if.led3_rgb_o == 3'b111) saw_on = 1'b1;
      if (bus_if.led3_rgb_o == 3'b000) saw_off = 1'b1;
      if (bus_if.led2_rgb_o != 3'b111) led2_steady = 1'b0;
    end
    check("pending_blink", {30'd0, saw_on, saw_off}, 32'd3);
    check("pending_led2_steady", {31'd0, led2_steady}, 32'd1);
    cycles(1);
    bus_if.sw_i = 4'b0010;
    cycles(10);
    check("pending_retarget", {31'd0, bus_if.pending_o}, 32'd1);
    expect_mode(4'b0010, {3'b000, 3'b000, 3'b111, 3'b000}, 4'd0);
    bus_if.busy_i = 1'b0;
    cycles(5);
    check("pending_cleared", {31'd0, bus_if.pending_o}, 32'd0);

    expect_mode(4'b0001, {3'b000, 3'b000, 3'b000, 3'b111}, 4'd0);
    bus_if.sw_i = 4'b0001;
    cycles(12);
    for (int i = 0; i < 6; i++) begin
      expect_sel(exp_sel[i], exp_line[i], exp_led0[i]);
      press();
    end
    check("led0_after_presses", {29'd0, bus_if.led0_rgb_o}, 32'b010);

    bus_if.busy_i = 1'b1;
    press();
    check("sel_busy_dropped", {29'd0, bus_if.sel_idx_o}, 32'd1);
    bus_if.busy_i = 1'b0;
    cycles(2);
    expect_sel(3'd2, 4'd2, 3'b001);
    press();
    check("sel_after_busy", {29'd0, bus_if.sel_idx_o}, 32'd2);

    bus_if.busy_i = 1'b1;
    bus_if.sw_i   = 4'b0100;
    cycles(10);
    check("pending_before_reset", {31'd0, bus_if.pending_o}, 32'd1);
    bus_if.btn_sel_i = 1'b1;
    cycles(3);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    bus_if.btn_sel_i = 1'b0;
    bus_if.busy_i    = 1'b0;
    cycles(2);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.mode_change_o) pulses++;
    end
    check("no_pulse_after_reset", pulses, 32'd0);
    expect_mode(4'b0100, {3'b000, 3'b111, 3'b000, 3'b000}, 4'd0);
    cycles(14);
    check("mode_after_reset", {28'd0, bus_if.mode_o}, 32'h4);

    cycles(4);
    check("mode_queue_drained", mode_q.size(), 32'd0);
    check("sel_queue_drained", sel_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
